// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown controller: state encoding, counter
// width default and the all-zero count constant.
package countdown_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    typedef logic [WIDTH_DEF-1:0] count_t;

    localparam count_t ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/eq_0.sv
// Zero detector: flags when the input vector is all zeros.
module eq_0 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] value,
    output logic             is_zero
);

    assign is_zero = (value == '0);

endmodule

// File: rtl/countdown_ctrl.sv
// Loadable down-counter controller with hold, abort and optional auto-reload;
// busy/done are decoded straight from the registered state.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0,
    parameter int WIDTH       = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             hold,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic             is_zero
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_next;

    eq_0 #(.WIDTH(WIDTH)) u_eq_0 (
        .value   (count),
        .is_zero (is_zero)
    );

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload;
        case (state)
            IDLE: begin
                if (start) begin
                    count_next  = load_val;
                    reload_next = load_val;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    count_next = ZERO;
                    state_next = IDLE;
                end else if (is_zero) begin
                    state_next = DONE;
                end else if (!hold) begin
                    count_next = count - 1'b1;
                end
            end
            DONE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (start) begin
                    count_next  = load_val;
                    reload_next = load_val;
                    state_next  = RUN;
                end else if (AUTO_RELOAD) begin
                    count_next = reload;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                // The spare encoding falls back to a clean idle.
                count_next = ZERO;
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so all state updates on the edge together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= ZERO;
            reload <= ZERO;
        end else begin
            state  <= state_next;
            count  <= count_next;
            reload <= reload_next;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench: drives both AUTO_RELOAD variants from one stimulus stream
// and compares each cycle's outputs against a behavioural countdown model.
module tb_countdown_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] load_val;
    logic       hold;
    logic       abort;

    logic       busy0, done0, zero0;
    logic [3:0] count0;
    logic       busy1, done1, zero1;
    logic [3:0] count1;

    always #5 clock = ~clock;

    countdown_ctrl #(.AUTO_RELOAD(1'b0), .WIDTH(4)) dut0 (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .load_val (load_val),
        .hold     (hold),
        .abort    (abort),
        .busy     (busy0),
        .done     (done0),
        .count    (count0),
        .is_zero  (zero0)
    );

    countdown_ctrl #(.AUTO_RELOAD(1'b1), .WIDTH(4)) dut1 (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .load_val (load_val),
        .hold     (hold),
        .abort    (abort),
        .busy     (busy1),
        .done     (done1),
        .count    (count1),
        .is_zero  (zero1)
    );

    typedef struct {
        int         cyc;
        logic [6:0] e0;
        logic [6:0] e1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model per instance: mode 0 = waiting, 1 = counting, 2 = finished.
    int m_mode[2];
    int m_cnt[2];
    int m_reload[2];

    localparam logic [6:0] RESET_OUT = 7'b0_0_0000_1;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got busy,done,count,zero=%b_%b_%h_%b expected %b_%b_%h_%b",
                     name, act[6], act[5], act[4:1], act[0], exp[6], exp[5], exp[4:1], exp[0]);
        end
    endtask

    function automatic logic [6:0] m_out(input int i);
        return {m_mode[i] == 1, m_mode[i] == 2, 4'(m_cnt[i]), m_cnt[i] == 0};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]   = 0;
            m_cnt[i]    = 0;
            m_reload[i] = 0;
        end
    endfunction

    function automatic void model_edge(input int i, input bit auto_reload);
        if (m_mode[i] == 1) begin
            if (abort) begin
                m_cnt[i]  = 0;
                m_mode[i] = 0;
            end else if (m_cnt[i] == 0) begin
                m_mode[i] = 2;
            end else if (!hold) begin
                m_cnt[i] = m_cnt[i] - 1;
            end
        end else if (m_mode[i] == 2 && abort) begin
            m_mode[i] = 0;
        end else if (start) begin
            m_cnt[i]    = int'(load_val);
            m_reload[i] = int'(load_val);
            m_mode[i]   = 1;
        end else if (m_mode[i] == 2 && auto_reload) begin
            m_cnt[i]  = m_reload[i];
            m_mode[i] = 1;
        end else begin
            m_mode[i] = 0;
        end
    endfunction

    // Apply inputs for one rising edge, then record what both DUTs must show after it.
    task automatic step(input logic s, input logic [3:0] lv, input logic h, input logic a);
        exp_t e;
        start    = s;
        load_val = lv;
        hold     = h;
        abort    = a;
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            model_edge(0, 1'b0);
            model_edge(1, 1'b1);
        end
        cyc++;
        e.cyc = cyc;
        e.e0  = m_out(0);
        e.e1  = m_out(1);
        sb.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        step(1'b0, 4'd0, 1'b0, 1'b1);
        idle(1);
    endtask

    // Reset is pulsed between edges and must act on the outputs immediately.
    task automatic async_reset();
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("async reset dut0", {busy0, done0, count0, zero0}, RESET_OUT);
        check("async reset dut1", {busy1, done1, count1, zero1}, RESET_OUT);
        model_reset();
        step(1'b0, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("dut0 cycle %0d", e.cyc), {busy0, done0, count0, zero0}, e.e0);
                check($sformatf("dut1 cycle %0d", e.cyc), {busy1, done1, count1, zero1}, e.e1);
            end
        end
    end

    initial begin : stimulus
        reset_n  = 1'b0;
        start    = 1'b0;
        load_val = 4'd0;
        hold     = 1'b0;
        abort    = 1'b0;
        model_reset();
        #2;
        check("reset dut0", {busy0, done0, count0, zero0}, RESET_OUT);
        check("reset dut1", {busy1, done1, count1, zero1}, RESET_OUT);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Plain countdown from 3, first start right after reset release.
        step(1'b1, 4'd3, 1'b0, 1'b0);
        idle(6);
        settle();

        // Hold for two cycles at count 3.
        step(1'b1, 4'd5, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        idle(6);
        settle();

        // Abort at count 4, plus abort/hold ignored while idle.
        step(1'b1, 4'd9, 1'b0, 1'b0);
        idle(5);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        idle(2);
        settle();

        // Auto-reload of 2, then a restart with 1 issued during the done cycle.
        step(1'b1, 4'd2, 1'b0, 1'b0);
        idle(7);
        step(1'b1, 4'd1, 1'b0, 1'b0);
        idle(5);
        settle();

        // Zero load, with a second start during the single run cycle.
        step(1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        idle(3);
        settle();

        // Asynchronous reset at count 6, then an immediate restart.
        step(1'b1, 4'd8, 1'b0, 1'b0);
        idle(2);
        async_reset();
        idle(3);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        idle(5);
        settle();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(3) == 0, 4'($urandom_range(15)),
                     $urandom_range(3) == 0, $urandom_range(15) == 0);
            end
        end

        repeat (2) @(negedge clock);
        #1;
        check("scoreboard drained", 7'(sb.size()), 7'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
